// File: rtl/vector_regfile_if.sv
// Bundle of the read, write and stream-load signals of vector_regfile.
// The master drives requests; the slave (the register file) returns read data and load status.
interface vector_regfile_if #(
  parameter int WIDTH    = 16,
  parameter int LANES    = 16,
  parameter int NUM_REGS = 4
);
  localparam int RB = $clog2(NUM_REGS);
  localparam int LB = $clog2(LANES);
  localparam int VW = LANES * WIDTH;

  logic [RB-1:0]    rd0_addr;
  logic [VW-1:0]    rd0_data;
  logic [RB-1:0]    rd1_addr;
  logic [VW-1:0]    rd1_data;
  logic             we;
  logic [RB+LB-1:0] write_addr;
  logic [WIDTH-1:0] write_data;
  logic             full_we;
  logic [RB-1:0]    full_addr;
  logic [LANES-1:0] full_mask;
  logic [VW-1:0]    full_write_data;
  logic             ld_start;
  logic [RB-1:0]    ld_addr;
  logic             ld_valid;
  logic [WIDTH-1:0] ld_data;
  logic             ld_ready;
  logic             ld_done;
  logic [NUM_REGS-1:0] busy;

  modport master (
    output rd0_addr, rd1_addr, we, write_addr, write_data,
           full_we, full_addr, full_mask, full_write_data,
           ld_start, ld_addr, ld_valid, ld_data,
    input  rd0_data, rd1_data, ld_ready, ld_done, busy
  );

  modport slave (
    input  rd0_addr, rd1_addr, we, write_addr, write_data,
           full_we, full_addr, full_mask, full_write_data,
           ld_start, ld_addr, ld_valid, ld_data,
    output rd0_data, rd1_data, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/vector_regfile.sv
// Vector register bank: two registered read ports, element and masked full-vector writes,
// and a lane-by-lane stream loader that owns its target register until the last lane lands.
module vector_regfile #(
  parameter int WIDTH    = 16,
  parameter int LANES    = 16,
  parameter int NUM_REGS = 4
) (
  input  logic clk,
  input  logic rst,
  vector_regfile_if.slave bus
);
  localparam int RB = $clog2(NUM_REGS);
  localparam int LB = $clog2(LANES);
  localparam int VW = LANES * WIDTH;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state_reg, state_next;
  logic [RB-1:0] tgt_reg, tgt_next;
  logic [LB-1:0] cnt_reg, cnt_next;
  logic          done_reg, done_next;
  logic          accept;

  logic [NUM_REGS-1:0] busy_vec;
  logic [VW-1:0]       regs [NUM_REGS];
  logic [VW-1:0]       rd0_reg, rd1_reg;
  logic [RB-1:0]       wr_sel;
  logic [LB-1:0]       wr_lane;

  assign wr_sel  = bus.write_addr[RB+LB-1:LB];
  assign wr_lane = bus.write_addr[LB-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      tgt_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tgt_next   = tgt_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.ld_start) begin
          tgt_next   = bus.ld_addr;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (bus.ld_valid) begin
          accept = 1'b1;
          if (cnt_reg == LB'(LANES - 1)) begin
            cnt_next   = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Each lane picks its source independently: stream load, then full write, then element write.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [VW-1:0] vec_reg, vec_next;

    assign busy_vec[gi] = (state_reg == LOAD) && (tgt_reg == RB'(gi));

    always_comb begin
      vec_next = vec_reg;
      for (int l = 0; l < LANES; l++) begin
        if (accept && (tgt_reg == RB'(gi)) && (cnt_reg == LB'(l))) begin
          vec_next[l*WIDTH +: WIDTH] = bus.ld_data;
        end else if (!busy_vec[gi] && bus.full_we && (bus.full_addr == RB'(gi))
                     && bus.full_mask[l]) begin
          vec_next[l*WIDTH +: WIDTH] = bus.full_write_data[l*WIDTH +: WIDTH];
        end else if (!busy_vec[gi] && bus.we && (wr_sel == RB'(gi))
                     && (wr_lane == LB'(l))) begin
          vec_next[l*WIDTH +: WIDTH] = bus.write_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) vec_reg <= '0;
      else     vec_reg <= vec_next;
    end

    assign regs[gi] = vec_reg;
  end

  // Read ports sample the current contents, so same-edge writes are seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_reg <= '0;
      rd1_reg <= '0;
    end else begin
      rd0_reg <= regs[bus.rd0_addr];
      rd1_reg <= regs[bus.rd1_addr];
    end
  end

  assign bus.rd0_data = rd0_reg;
  assign bus.rd1_data = rd1_reg;
  assign bus.ld_ready = (state_reg == LOAD);
  assign bus.ld_done  = done_reg;
  assign bus.busy     = busy_vec;
endmodule
